m65c02_mem_resp: RTL and testbench

- Memory-side responder for the M65C02A core bus.
- Accepts the core's address output (AO), I/O operation and write data. Decodes each access into one of three regions: IO page, ROM, or RAM.
- Inserts a per-region number of wait states by driving the core's Rdy input low, returns read data to the core, and strobes the external/block memory.
- Sits between the core and the memory array; it is the target end of the address and ready handshake the core initiates.

---
 rtl/m65c02_mem_resp.sv | 145 ++++++++++++++
 tb/tb_m65c02_mem_resp.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/m65c02_mem_resp.sv
// Memory-side responder for the M65C02A core bus: decodes IO/ROM/RAM, inserts wait states, strobes memory.
// Optional ROM write protection is enabled by defining M65C02_MEM_RESP_WPROT_EN.
module m65c02_mem_resp #(
    parameter logic [7:0]  pIO_Page  = 8'hFF,
    parameter logic [15:0] pROM_Base = 16'hC000,
    parameter logic [3:0]  pWS_IO    = 4'd2,
    parameter logic [3:0]  pWS_ROM   = 4'd1,
    parameter logic [3:0]  pWS_RAM   = 4'd0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] AO,
    input  logic [1:0]  IO_Op,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        Rdy,
    output logic [15:0] MA,
    output logic [7:0]  MDO,
    input  logic [7:0]  MDI,
    output logic        MRE,
    output logic        MWE,
    output logic        Sel_IO,
    output logic        WP_Err
);

    // state   | meaning
    // ST_IDLE | no access in progress; decode AO, complete zero-wait accesses
    // ST_WAIT | counting wait states of a latched access; completes when Cnt=0
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic [1:0] {RGN_RAM, RGN_ROM, RGN_IO} rgn_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    rgn_t        rgn_q, rgn_d;
    logic [1:0]  op_q, op_d;

    rgn_t        dec_rgn;
    logic [3:0]  dec_ws;
    rgn_t        cur_rgn;
    logic [1:0]  cur_op;
    logic        rdy;
    logic        wr_done;
    logic        wr_blk;

    always_comb begin
        dec_rgn = RGN_RAM;
        if (AO[15:8] == pIO_Page)
            dec_rgn = RGN_IO;
        else if (AO >= pROM_Base)
            dec_rgn = RGN_ROM;
    end

    always_comb begin
        dec_ws = pWS_RAM;
        case (dec_rgn)
            RGN_IO:  dec_ws = pWS_IO;
            RGN_ROM: dec_ws = pWS_ROM;
            default: dec_ws = pWS_RAM;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rgn_d   = rgn_q;
        op_d    = op_q;
        cur_rgn = dec_rgn;
        cur_op  = IO_Op;
        rdy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (IO_Op == OP_NONE) begin
                    rdy = 1'b1;
                end else if (dec_ws == 4'd0) begin
                    rdy = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = dec_ws - 4'd1;
                    rgn_d   = dec_rgn;
                    op_d    = IO_Op;
                end
            end
            ST_WAIT: begin
                // The core holds the bus stable, so the latched decode is authoritative here.
                cur_rgn = rgn_q;
                cur_op  = op_q;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdy     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (Rst)
            rdy = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rgn_q   <= RGN_RAM;
            op_q    <= OP_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rgn_q   <= rgn_d;
            op_q    <= op_d;
        end
    end

    assign wr_done = rdy && (cur_op == OP_WR);

`ifdef M65C02_MEM_RESP_WPROT_EN
    logic wp_err_q;

    assign wr_blk = (cur_rgn == RGN_ROM);

    always_ff @(posedge Clk) begin
        if (Rst)
            wp_err_q <= 1'b0;
        else if (wr_done && wr_blk)
            wp_err_q <= 1'b1;
    end

    assign WP_Err = wp_err_q;
`else
    assign wr_blk = 1'b0;
    assign WP_Err = 1'b0;
`endif

    assign Rdy    = rdy;
    assign MA     = AO;
    assign MDO    = DO;
    assign MRE    = cur_op[1] && !Rst;
    assign MWE    = wr_done && !wr_blk;
    assign DI     = (rdy && cur_op[1]) ? MDI : 8'h00;
    assign Sel_IO = (cur_rgn == RGN_IO);

endmodule

// File: tb/tb_m65c02_mem_resp.sv
// Directed, table-driven bench for m65c02_mem_resp with default parameters.
module tb_m65c02_mem_resp;

    logic        Clk;
    logic        Rst;
    logic [15:0] AO;
    logic [1:0]  IO_Op;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        Rdy;
    logic [15:0] MA;
    logic [7:0]  MDO;
    logic [7:0]  MDI;
    logic        MRE;
    logic        MWE;
    logic        Sel_IO;
    logic        WP_Err;

    int n_cmp = 0;
    int n_err = 0;

`ifdef M65C02_MEM_RESP_WPROT_EN
    localparam logic WPROT = 1'b1;
`else
    localparam logic WPROT = 1'b0;
`endif

    m65c02_mem_resp dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .AO     (AO),
        .IO_Op  (IO_Op),
        .DO     (DO),
        .DI     (DI),
        .Rdy    (Rdy),
        .MA     (MA),
        .MDO    (MDO),
        .MDI    (MDI),
        .MRE    (MRE),
        .MWE    (MWE),
        .Sel_IO (Sel_IO),
        .WP_Err (WP_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic [15:0] ao;
        logic [1:0]  op;
        logic [7:0]  dout;
        logic [7:0]  mdi;
        logic        e_rdy;
        logic        e_mre;
        logic        e_mwe;
        logic [7:0]  e_di;
        logic        e_sel;
        logic        e_wp;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Apply one cycle of inputs, check combinational outputs mid-cycle, then cross the clock edge.
    task automatic cycle(input vec_t v, input int idx);
        Rst   = v.rst;
        AO    = v.ao;
        IO_Op = v.op;
        DO    = v.dout;
        MDI   = v.mdi;
        @(negedge Clk);
        chk("Rdy",    idx, {15'd0, Rdy},    {15'd0, v.e_rdy});
        chk("MRE",    idx, {15'd0, MRE},    {15'd0, v.e_mre});
        chk("MWE",    idx, {15'd0, MWE},    {15'd0, v.e_mwe});
        chk("DI",     idx, {8'd0, DI},      {8'd0, v.e_di});
        chk("Sel_IO", idx, {15'd0, Sel_IO}, {15'd0, v.e_sel});
        chk("WP_Err", idx, {15'd0, WP_Err}, {15'd0, v.e_wp});
        chk("MA",     idx, MA,              v.ao);
        chk("MDO",    idx, {8'd0, MDO},     {8'd0, v.dout});
        @(posedge Clk);
        #1;
    endtask

    function automatic vec_t mk(logic rst, logic [15:0] ao, logic [1:0] op, logic [7:0] dout, logic [7:0] mdi,
                                logic e_rdy, logic e_mre, logic e_mwe, logic [7:0] e_di, logic e_sel, logic e_wp);
        vec_t v;
        v.rst = rst; v.ao = ao; v.op = op; v.dout = dout; v.mdi = mdi;
        v.e_rdy = e_rdy; v.e_mre = e_mre; v.e_mwe = e_mwe; v.e_di = e_di; v.e_sel = e_sel; v.e_wp = e_wp;
        return v;
    endfunction

    initial begin
        int waited;
        //               rst ao        op     do     mdi    rdy mre mwe di     sel wp
        vecs[0]  = mk(1, 16'hFFFC, 2'b10, 8'h00, 8'hEE, 0,  0,  0,  8'h00, 1,  0);
        vecs[1]  = mk(1, 16'hFFFC, 2'b10, 8'h00, 8'hEE, 0,  0,  0,  8'h00, 1,  0);
        vecs[2]  = mk(1, 16'hFFFC, 2'b10, 8'h00, 8'hEE, 0,  0,  0,  8'h00, 1,  0);
        vecs[3]  = mk(0, 16'h0200, 2'b10, 8'h00, 8'h5A, 1,  1,  0,  8'h5A, 0,  0);
        vecs[4]  = mk(0, 16'hC000, 2'b11, 8'h00, 8'hA5, 0,  1,  0,  8'h00, 0,  0);
        vecs[5]  = mk(0, 16'hC000, 2'b11, 8'h00, 8'hA5, 1,  1,  0,  8'hA5, 0,  0);
        vecs[6]  = mk(0, 16'hBFFF, 2'b10, 8'h00, 8'h11, 1,  1,  0,  8'h11, 0,  0);
        vecs[7]  = mk(0, 16'hFF10, 2'b01, 8'h3C, 8'h77, 0,  0,  0,  8'h00, 1,  0);
        vecs[8]  = mk(0, 16'hFF10, 2'b01, 8'h3C, 8'h77, 0,  0,  0,  8'h00, 1,  0);
        vecs[9]  = mk(0, 16'hFF10, 2'b01, 8'h3C, 8'h77, 1,  0,  1,  8'h00, 1,  0);
        vecs[10] = mk(0, 16'hFF00, 2'b00, 8'h00, 8'h77, 1,  0,  0,  8'h00, 1,  0);
        vecs[11] = mk(0, 16'hFF00, 2'b10, 8'h00, 8'hC3, 0,  1,  0,  8'h00, 1,  0);
        vecs[12] = mk(0, 16'hFF00, 2'b10, 8'h00, 8'hC3, 0,  1,  0,  8'h00, 1,  0);
        vecs[13] = mk(0, 16'hFF00, 2'b10, 8'h00, 8'hC3, 1,  1,  0,  8'hC3, 1,  0);
        vecs[14] = mk(0, 16'h1234, 2'b01, 8'h99, 8'h00, 1,  0,  1,  8'h00, 0,  0);
        vecs[15] = mk(0, 16'hC000, 2'b01, 8'h42, 8'h00, 0,  0,  0,  8'h00, 0,  0);
        vecs[16] = mk(0, 16'hE000, 2'b01, 8'h42, 8'h00, 1,  0,  !WPROT, 8'h00, 0, 0);
        vecs[17] = mk(0, 16'h0000, 2'b00, 8'h00, 8'h00, 1,  0,  0,  8'h00, 0,  WPROT);
        vecs[18] = mk(0, 16'h0200, 2'b10, 8'h00, 8'h01, 1,  1,  0,  8'h01, 0,  WPROT);

        Rst = 1'b1; AO = 16'hFFFC; IO_Op = 2'b10; DO = 8'h00; MDI = 8'h00;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 19; i++)
            cycle(vecs[i], i);

        // Reset lands in the second cycle of an IO write: the write must be abandoned.
        cycle(mk(0, 16'hFF10, 2'b01, 8'h3C, 8'h00, 0, 0, 0, 8'h00, 1, WPROT), 100);
        cycle(mk(1, 16'hFF10, 2'b01, 8'h3C, 8'h00, 0, 0, 0, 8'h00, 1, WPROT), 101);
        cycle(mk(0, 16'h0000, 2'b00, 8'h3C, 8'h00, 1, 0, 0, 8'h00, 0, 0), 102);
        cycle(mk(0, 16'h0000, 2'b00, 8'h3C, 8'h00, 1, 0, 0, 8'h00, 0, 0), 103);
        cycle(mk(0, 16'h0200, 2'b10, 8'h00, 8'h5A, 1, 1, 0, 8'h5A, 0, 0), 104);

        // IO read timed by a bounded wait on Rdy: two wait cycles before completion.
        Rst = 1'b0; AO = 16'hFF20; IO_Op = 2'b10; DO = 8'h00; MDI = 8'h6B;
        waited = 0;
        @(negedge Clk);
        while (!Rdy && waited < 8) begin
            waited++;
            @(posedge Clk);
            @(negedge Clk);
        end
        chk("io_wait_cycles", 200, 16'(waited), 16'd2);
        chk("io_done_di",     200, {8'd0, DI}, 16'h006B);
        @(posedge Clk);
        #1;
        cycle(mk(0, 16'h0000, 2'b00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0), 201);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
